seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for a bank of 7-segment digits sharing one segment bus.
//   Holds a double-buffered BCD word and cycles the shared segment lines across NUM_DIGITS digits.
//   Inserts an all-off blanking gap between digits to prevent ghosting.
//   Accepts new display values through a valid/ready handshake and swaps them in only at frame boundaries.
// PARAMETERS
//   NUM_DIGITS  4      number of digits scanned (>=2)
//   SCAN_DIV    50000  clk cycles per digit slot, including blanking (> BLANK_CYC)
//   BLANK_CYC   16     clk cycles of all-off at the start of each slot (>=1)
// PORTS
//   clk         in   1             clock
//   rst         in   1             synchronous, active-high reset
//   en          in   1             display enable; 0 forces all digits off
//   load_valid  in   1             new display word offered
//   load_ready  out  1             pending buffer can accept a word
//   load_data   in   4*NUM_DIGITS  BCD nibbles; nibble i drives digit i (digit 0 = LSB)
//   dp_in       in   NUM_DIGITS    decimal point per digit, 1 = lit; sampled live, not buffered
//   segment     out  7             {a,b,c,d,e,f,g}, active-low (0 = lit)
//   dp_n        out  1             decimal point, active-low
//   an_n        out  NUM_DIGITS    digit enables, active-low, at most one low at a time
//   frame_done  out  1             one-cycle pulse at the end of the last digit slot
// BEHAVIOUR
//   Reset values: segment=7'b1111111, dp_n=1, an_n=all 1, frame_done=0, load_ready=1.
//   Reset clears the active and pending buffers to 0, digit index to 0, and state to IDLE.
//   FSM states:
//     IDLE  -> BLANK when en=1
//     BLANK -> SHOW after BLANK_CYC cycles
//     SHOW  -> BLANK after SCAN_DIV-BLANK_CYC cycles; digit index +1
//     Any state -> IDLE on the cycle after en=0 is sampled.
//   Wrap: leaving SHOW at index NUM_DIGITS-1 sets index to 0 and pulses frame_done for 1 cycle.
//   Outputs are registered, one cycle after state/index. In IDLE and BLANK, all outputs are off.
//   In SHOW: an_n[idx]=0, segment=decode(active[idx]), dp_n=~dp_in[idx].
//   Decode table, nibble -> segment:
//     0=0000001  1=1001111  2=0010010  3=0000110  4=1001100
//     5=0100100  6=0100000  7=0001111  8=0000000  9=0000100
//   Nibbles 10..15 decode to 7'b1111111 (digit dark; the anode is still driven low).
//   Handshake: transfer occurs when load_valid & load_ready; the word goes to pending; pending_full is set.
//   load_ready = ~pending_full | swap, so a word presented in a swap cycle is accepted.
//   swap = pending_full & (frame_done condition | state==IDLE); swap copies pending->active and clears pending_full.
//   Simultaneous swap + accept: active gets the old pending word; pending gets the new word and stays full.
//   Entering IDLE resets the prescaler and the index. A re-enable always starts at digit 0 with a full BLANK.
// CONFIGURATION
//   SEG_SCAN_LZB_EN defined: leading-zero blanking.
//     Contiguous zero nibbles from digit NUM_DIGITS-1 downward keep an_n high and segment off during their SHOW slot.
//     Slot timing is unchanged. Digit 0 is never blanked.
//   SEG_SCAN_LZB_EN undefined: every digit is displayed, including leading zeros.
// STRUCTURE
//   seg_pkg: SEG_OFF constant (7'b1111111), seg_state_t enum {IDLE,BLANK,SHOW}, and the BCD->segment decode function.
//   Sub-module seg_decode: combinational nibble->segment using the seg_pkg function, instantiated once on the muxed nibble.
//   Prescaler counter width is $clog2(SCAN_DIV); index width is $clog2(NUM_DIGITS).
// TESTING  (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2)
//   1. Reset with en=0 -> segment=1111111, an_n=1111, dp_n=1, load_ready=1, frame_done=0 held indefinitely.
//   2. Load 16'h1234 in IDLE, then set en=1.
//      Expect: 2 cycles off, then an_n=1110 with segment=1001100 for 6 cycles.
//      Then digits 1,2,3 show 0000110, 0010010, 1001111; frame_done pulses every 32 cycles.
//   3. Mid-frame, load 16'h5678 then 16'h9999 -> the second load stalls (load_ready=0) until the frame_done cycle.
//      The next frame shows 5678; the frame after shows 9999.
//   4. Load 16'h00A0 -> digit 1 slot has an_n=1101 and segment=1111111; digits 0,2,3 show 0000001.
//   5. Drop en during digit 2 SHOW -> all outputs off within 2 cycles.
//      Re-enable -> 2 blank cycles, then digit 0, with no frame_done from the aborted frame.
//   6. With SEG_SCAN_LZB_EN, load 16'h0042 -> digits 3,2 keep an_n high.
//      Load 16'h0000 -> only digit 0 lights, showing 0000001.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types, constants and the BCD-to-segment decode for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } seg_state_t;

  // Active-low {a,b,c,d,e,f,g}; non-BCD nibbles leave the digit dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble-to-segment decoder used on the currently scanned digit.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segment
);

  assign segment = bcd_to_seg(nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered BCD word.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              segment,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output seg_state_t              dbg_state
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  seg_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;

  logic [4*NUM_DIGITS-1:0] active, pending;
  logic                    pending_full;
  logic                    frame_cond, swap, accept;
  logic [3:0]              nibble;
  logic [6:0]              seg_dec;
  logic [NUM_DIGITS-1:0]   lz;

  // Handshake: a word transfers on any cycle with load_valid & load_ready;
  // load_valid/load_data must stay stable until that cycle. A pending word
  // is promoted to active only at a frame boundary or while idle.
  assign frame_cond = en && state == SHOW && cnt == SHOW_LAST && idx == IDX_LAST;
  assign swap       = pending_full && (frame_cond || state == IDLE);
  assign load_ready = ~pending_full | swap;
  assign accept     = load_valid & load_ready;
  assign dbg_state  = state;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    if (!en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx = SHOW;
            cnt_nx   = '0;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      if (swap) active <= pending;
      if (accept) pending <= load_data;
      pending_full <= accept | (pending_full & ~swap);
    end
  end

  assign nibble = active[4*idx +: 4];

  seg_decode u_dec (
    .nibble  (nibble),
    .segment (seg_dec)
  );

`ifdef SEG_SCAN_LZB_EN
  // Zero run from the top digit down; digit 0 always shows.
  logic lead;
  always_comb begin
    lz   = '0;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead  = lead & (active[4*i +: 4] == 4'd0);
      lz[i] = lead;
    end
  end
`else
  assign lz = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      segment    <= SEG_OFF;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_cond;
      segment    <= SEG_OFF;
      dp_n       <= 1'b1;
      an_n       <= '1;
      if (state == SHOW && !lz[idx]) begin
        an_n    <= ~(NUM_DIGITS'(1) << idx);
        segment <= seg_dec;
        dp_n    <= ~dp_in[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// Expected frames depend on whether SEG_SCAN_LZB_EN is defined.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SX = 7'b1111111;

  logic        clk, rst, en, load_valid, load_ready, dp_n, frame_done;
  logic [15:0] load_data;
  logic [3:0]  dp_in, an_n;
  logic [6:0]  segment;
  seg_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  int n;

  seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .dp_in      (dp_in),
    .segment    (segment),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_off(input string tag);
    check({tag, ".an_n"}, 32'(an_n), 32'hF);
    check({tag, ".segment"}, 32'(segment), 32'(SX));
    check({tag, ".dp_n"}, 32'(dp_n), 32'h1);
  endtask

  // Starts on the first displayed cycle of digit 0 and ends on the next one.
  task automatic check_frame(input string tag, input logic [3:0][6:0] segs, input logic [3:0] lit);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int d = 0; d < 4; d++) begin
      e_an  = lit[d] ? ~(4'b0001 << d) : 4'hF;
      e_seg = lit[d] ? segs[d] : SX;
      for (int c = 0; c < 6; c++) begin
        e_dp = lit[d] ? ~dp_in[d] : 1'b1;
        check({tag, ".an_n"}, 32'(an_n), 32'(e_an));
        check({tag, ".segment"}, 32'(segment), 32'(e_seg));
        check({tag, ".dp_n"}, 32'(dp_n), 32'(e_dp));
        check({tag, ".frame_done"}, 32'(frame_done), 32'(d == 3 && c == 5));
        tick();
      end
      for (int c = 0; c < 2; c++) begin
        check_off({tag, ".gap"});
        check({tag, ".gap_frame_done"}, 32'(frame_done), 32'h0);
        tick();
      end
    end
  endtask

  // Load a word early in the frame, then run to the start of the frame that shows it.
  task automatic load_and_skip(input logic [15:0] word);
    load_valid = 1'b1;
    load_data  = word;
    check("load_ready_free", 32'(load_ready), 32'h1);
    tick();
    load_valid = 1'b0;
    repeat (31) tick();
  endtask

  // Scoreboard of display words in load order
  logic [15:0] exp_q[$];

  initial begin
    rst = 1'b1; en = 1'b0; load_valid = 1'b0; load_data = '0; dp_in = '0;
    repeat (3) tick();
    rst = 1'b0;

    // 1. reset / idle outputs held
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    repeat (5) begin
      tick();
      check_off("idle");
      check("idle_load_ready", 32'(load_ready), 32'h1);
      check("idle_frame_done", 32'(frame_done), 32'h0);
    end

    // 2. load in IDLE, then enable
    exp_q.push_back(16'h1234);
    load_valid = 1'b1;
    load_data  = exp_q[0];
    tick();
    check("idle_swap_ready", 32'(load_ready), 32'h1);
    load_valid = 1'b0;
    tick();
    dp_in = 4'b0101;
    en = 1'b1;
    repeat (3) begin
      tick();
      check_off("start_blank");
    end
    tick();
    check_frame("f1234a", {S1, S2, S3, S4}, 4'hF);
    check_frame("f1234b", {S1, S2, S3, S4}, 4'hF);
    void'(exp_q.pop_front());

    // 3. second load stalls until the frame boundary
    exp_q.push_back(16'h5678);
    exp_q.push_back(16'h9999);
    dp_in = 4'b1010;
    load_valid = 1'b1;
    load_data  = exp_q[0];
    tick();
    check("stall_ready", 32'(load_ready), 32'h0);
    load_data = exp_q[1];
    n = 0;
    while (!load_ready && n < 100) begin
      tick();
      n++;
    end
    check("stall_cycles", 32'(n), 32'd27);
    tick();
    load_valid = 1'b0;
    check("boundary_frame_done", 32'(frame_done), 32'h1);
    check("boundary_an_n", 32'(an_n), 32'h7);
    check("boundary_ready", 32'(load_ready), 32'h0);
    repeat (2) begin
      tick();
      check_off("boundary_gap");
    end
    tick();
    check_frame("f5678", {S5, S6, S7, S8}, 4'hF);
    check_frame("f9999", {S9, S9, S9, S9}, 4'hF);
    check("after_swap_ready", 32'(load_ready), 32'h1);

    // 4. non-BCD nibble stays dark with its anode driven
    dp_in = 4'b0000;
    load_and_skip(16'h00A0);
`ifdef SEG_SCAN_LZB_EN
    check_frame("f00A0", {S0, S0, SX, S0}, 4'b0011);
`else
    check_frame("f00A0", {S0, S0, SX, S0}, 4'b1111);
`endif

    // 5. drop enable during digit 2, then re-enable
    repeat (17) tick();
    check("mid_d2_an_n", 32'(an_n), 32'hB);
    en = 1'b0;
    tick();
    tick();
    check_off("disable");
    check("disable_state", 32'(dbg_state), 32'(IDLE));
    repeat (6) begin
      tick();
      check_off("disabled");
      check("disabled_frame_done", 32'(frame_done), 32'h0);
    end
    en = 1'b1;
    repeat (3) begin
      tick();
      check_off("restart_blank");
    end
    tick();
`ifdef SEG_SCAN_LZB_EN
    check_frame("restart", {S0, S0, SX, S0}, 4'b0011);
`else
    check_frame("restart", {S0, S0, SX, S0}, 4'b1111);
`endif

    // 6. leading zeros
    load_and_skip(16'h0042);
`ifdef SEG_SCAN_LZB_EN
    check_frame("f0042", {S0, S0, S4, S2}, 4'b0011);
`else
    check_frame("f0042", {S0, S0, S4, S2}, 4'b1111);
`endif
    load_and_skip(16'h0000);
`ifdef SEG_SCAN_LZB_EN
    check_frame("f0000", {S0, S0, S0, S0}, 4'b0001);
`else
    check_frame("f0000", {S0, S0, S0, S0}, 4'b1111);
`endif

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
